// File: rtl/i2c_master_arbiter_pkg.sv
// i2c_master_arbiter_pkg: shared state encoding and helpers for the i2c master arbiter
package i2c_master_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARB        = 3'd1,
        LAUNCH     = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4,
        DONE       = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_master_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first active request at or after ptr
//   req     in  N   request vector
//   ptr     in  IW  highest-priority index
//   gnt     out N   one-hot winner (0 when no request)
//   gnt_idx out IW  binary winner index
//   any     out 1   some request is active
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest active request wins.
    always_comb begin
        gnt_idx = '0;
        any     = |req;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) gnt_idx = IW'((int'(ptr) + k) % N);
        gnt = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master among N_REQ requesters
//   clk, rst            clock, synchronous active-high reset
//   req/req_cmd/req_data requester level requests, {addr,rw} commands, write bytes
//   grant/done/err       one-hot grant, one-hot completion pulse, timeout flag
//   rd_data              read byte latched at each successful completion
//   m_en/m_cmd/m_data    launch handshake towards i2c_master
//   m_busy/m_read_data   status and read byte from i2c_master
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int EN_CYCLES = 2,
    parameter int START_TMO = 64,
    parameter int XFER_TMO  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_cmd,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic [7:0]         rd_data,
    output logic               m_en,
    output logic [7:0]         m_cmd,
    output logic [7:0]         m_data,
    input  logic               m_busy,
    input  logic [7:0]         m_read_data
);

    localparam int CW = $clog2(max2(START_TMO, XFER_TMO)) + 1;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    ptr, gnt_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic             any, tmo;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_n = state;
        tmo     = 1'b0;
        case (state)
            IDLE:       if (|req && !m_busy) state_n = ARB;
            ARB:        state_n = any ? LAUNCH : IDLE;
            LAUNCH:     if (cnt == CW'(EN_CYCLES - 1)) state_n = WAIT_START;
            WAIT_START: begin
                if (m_busy) state_n = WAIT_DONE;
                else if (cnt == CW'(START_TMO - 1)) begin
                    state_n = DONE;
                    tmo     = 1'b1;
                end
            end
            WAIT_DONE:  begin
                if (!m_busy) state_n = DONE;
                else if (cnt == CW'(XFER_TMO - 1)) begin
                    state_n = DONE;
                    tmo     = 1'b1;
                end
            end
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    // done/err/rd_data are registered on entry to DONE so they are valid during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            grant   <= '0;
            done    <= '0;
            err     <= 1'b0;
            rd_data <= '0;
            m_en    <= 1'b0;
            m_cmd   <= '0;
            m_data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            done  <= '0;
            err   <= 1'b0;
            if (state == ARB && any) begin
                grant  <= gnt_oh;
                ptr    <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                m_cmd  <= req_cmd[8*gnt_idx +: 8];
                m_data <= req_data[8*gnt_idx +: 8];
                m_en   <= 1'b1;
            end
            if (state == LAUNCH && state_n == WAIT_START) m_en <= 1'b0;
            if (state != DONE && state_n == DONE) begin
                done <= grant;
                err  <= tmo;
                if (!tmo) rd_data <= m_read_data;
            end
            if (state == DONE) grant <= '0;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: randomized self-checking bench with a behavioural master and RR model
module tb_i2c_master_arbiter;

    localparam int N   = 3;
    localparam int EN  = 2;
    localparam int STO = 16;
    localparam int XTO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_cmd, req_data;
    logic [N-1:0]   grant, done;
    logic           err;
    logic [7:0]     rd_data;
    logic           m_en;
    logic [7:0]     m_cmd, m_data;
    logic           m_busy;
    logic [7:0]     m_read_data;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mptr = 0;
    logic [7:0] rd_model = 8'h00;

    i2c_master_arbiter #(.N_REQ(N), .EN_CYCLES(EN), .START_TMO(STO), .XFER_TMO(XTO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_cmd     (req_cmd),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .err         (err),
        .rd_data     (rd_data),
        .m_en        (m_en),
        .m_cmd       (m_cmd),
        .m_data      (m_data),
        .m_busy      (m_busy),
        .m_read_data (m_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic load_cmds();
        for (int i = 0; i < N; i++) begin
            req_cmd[8*i +: 8]  = 8'($urandom);
            req_data[8*i +: 8] = 8'($urandom);
        end
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 100 && grant === '0; n++) tick();
    endtask

    // mode 0: normal transfer, 1: master never goes busy, 2: master stays busy
    task automatic serve(input int w, input int mode, input bit drop);
        int g0, en_n;
        logic [N-1:0] eg;
        logic [7:0] ecmd, edat, rd;
        eg = '0;
        eg[w] = 1'b1;
        ecmd = req_cmd[8*w +: 8];
        edat = req_data[8*w +: 8];
        wait_grant();
        g0 = cyc;
        compared++;
        if (grant !== eg) begin mismatched++; $display("FAIL grant: got %b expected %b", grant, eg); end
        compared++;
        if (m_cmd !== ecmd) begin mismatched++; $display("FAIL m_cmd: got %h expected %h", m_cmd, ecmd); end
        compared++;
        if (m_data !== edat) begin mismatched++; $display("FAIL m_data: got %h expected %h", m_data, edat); end
        en_n = 0;
        while (m_en === 1'b1 && en_n < 20) begin
            en_n++;
            tick();
            if (drop && en_n == 1) req[w] = 1'b0;
        end
        compared++;
        if (en_n != EN) begin mismatched++; $display("FAIL m_en_width: got %0d expected %0d", en_n, EN); end
        if (mode == 0) begin
            repeat ($urandom_range(0, 4)) tick();
            rd = 8'($urandom);
            m_busy = 1'b1;
            m_read_data = rd;
            repeat ($urandom_range(1, 6)) tick();
            compared++;
            if (done !== '0) begin mismatched++; $display("FAIL early_done: got %b expected 0", done); end
            m_busy = 1'b0;
            tick();
            rd_model = rd;
        end else begin
            m_busy = (mode == 2);
            m_read_data = 8'($urandom);
            for (int n = 0; n < XTO + 20 && done === '0; n++) tick();
            m_busy = 1'b0;
            compared++;
            if (cyc - g0 != EN + (mode == 2 ? 1 + XTO : STO)) begin
                mismatched++;
                $display("FAIL timeout_latency: got %0d expected %0d", cyc - g0, EN + (mode == 2 ? 1 + XTO : STO));
            end
        end
        compared++;
        if (done !== eg) begin mismatched++; $display("FAIL done: got %b expected %b", done, eg); end
        compared++;
        if (err !== (mode != 0)) begin mismatched++; $display("FAIL err: got %b expected %b", err, mode != 0); end
        compared++;
        if (rd_data !== rd_model) begin mismatched++; $display("FAIL rd_data: got %h expected %h", rd_data, rd_model); end
        compared++;
        if (m_cmd !== ecmd || m_data !== edat) begin
            mismatched++;
            $display("FAIL cmd_stable: got %h/%h expected %h/%h", m_cmd, m_data, ecmd, edat);
        end
        mptr = (w + 1) % N;
        tick();
        compared++;
        if (done !== '0 || grant !== '0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL done_clear: got done=%b grant=%b err=%b expected 0", done, grant, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        m_busy = 1'b0;
        m_read_data = 8'h00;
        load_cmds();
        repeat (2) tick();
        compared++;
        if ({grant, done, err, m_en} !== '0) begin
            mismatched++;
            $display("FAIL reset_ctl: got grant=%b done=%b err=%b m_en=%b expected 0", grant, done, err, m_en);
        end
        compared++;
        if ({rd_data, m_cmd, m_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_data: got %h/%h/%h expected 0", rd_data, m_cmd, m_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int c0;
        req_cmd[7:0] = 8'hAA;
        req_data[7:0] = 8'hA5;
        c0 = cyc;
        req = 3'b001;
        wait_grant();
        compared++;
        if (cyc - c0 != 2) begin mismatched++; $display("FAIL grant_latency: got %0d expected 2", cyc - c0); end
        serve(pick(req, mptr), 0, 1'b0);
        req = '0;
    endtask

    task automatic test_simultaneous();
        load_cmds();
        req = 3'b111;
        while (req != '0) begin
            int w;
            w = pick(req, mptr);
            serve(w, 0, 1'b0);
            req[w] = 1'b0;
        end
    endtask

    task automatic test_hold();
        int w;
        load_cmds();
        req = 3'b100;
        w = pick(req, mptr);
        wait_grant();
        req[0] = 1'b1;
        serve(w, 0, 1'b0);
        serve(pick(req, mptr), 0, 1'b0);
        req[0] = 1'b0;
        serve(pick(req, mptr), 0, 1'b0);
        req = '0;
    endtask

    task automatic test_timeout();
        load_cmds();
        req = 3'b010;
        serve(pick(req, mptr), 1, 1'b0);
        load_cmds();
        serve(pick(req, mptr), 2, 1'b0);
        req = '0;
    endtask

    task automatic test_drop();
        load_cmds();
        req = 3'b010;
        serve(pick(req, mptr), 0, 1'b1);
        repeat (5) tick();
        compared++;
        if (grant !== '0) begin mismatched++; $display("FAIL drop_regrant: got %b expected 0", grant); end
    endtask

    task automatic test_reset_mid();
        load_cmds();
        req = 3'b001;
        wait_grant();
        for (int n = 0; n < 20 && m_en === 1'b1; n++) tick();
        req = '0;
        m_busy = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        compared++;
        if ({m_en, grant, done, err} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got m_en=%b grant=%b done=%b err=%b expected 0", m_en, grant, done, err);
        end
        rst = 1'b0;
        m_busy = 1'b0;
        mptr = 0;
        rd_model = 8'h00;
        load_cmds();
        req = 3'b011;
        serve(pick(req, mptr), 0, 1'b0);
        req[0] = 1'b0;
        serve(pick(req, mptr), 0, 1'b0);
        req = '0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            load_cmds();
            req = N'($urandom_range(1, (1 << N) - 1));
            while (req != '0) begin
                int w;
                w = pick(req, mptr);
                serve(w, 0, 1'b0);
                req[w] = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_hold();
        test_timeout();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
